// File: rtl/single_mem_arbiter_pkg.sv
// Shared types and constants for the two-port single-RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Block RAM read data appears one clock after the enable cycle.
  localparam int unsigned RD_LAT = 1;

endpackage

// File: rtl/single_mem_arbiter_if.sv
// Requester handshake bus and RAM bus of the single-RAM arbiter.
interface mem_arb_req_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
);
  import mem_arb_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface mem_arb_ram_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
);
  import mem_arb_pkg::*;

  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/single_mem_arbiter_slot_tick_gen.sv
// Free-running slot counter; slot_start marks the first clock of each slot.
module slot_tick_gen
  import mem_arb_pkg::*;
#(
  parameter int unsigned SLOT_CYC = 4
) (
  input  logic clk_100Mhz,
  input  logic Reset,
  output logic slot_start
);

  localparam int unsigned CNT_W = $clog2(SLOT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..SLOT_CYC-1; slot_start is registered so it equals (cnt == 0).
  always_ff @(posedge clk_100Mhz) begin
    if (Reset) begin
      cnt        <= '0;
      slot_start <= 1'b1;
    end else if (cnt == CNT_MAX) begin
      cnt        <= '0;
      slot_start <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      slot_start <= 1'b0;
    end
  end

endmodule

// File: rtl/single_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
module single_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned SLOT_CYC = 4
) (
  input  logic          clk_100Mhz,
  input  logic          Reset,
  mem_arb_req_if.slave  a_port,
  mem_arb_req_if.slave  b_port,
  mem_arb_ram_if.master ram,
  output logic          busy
);

  // The FSM needs three clocks per access, and the DONE cycle assumes RD_LAT = 1.
  if (SLOT_CYC < 3 || SLOT_CYC > 16) begin : g_bad_slot
    $error("SLOT_CYC must be in 3..16");
  end
  if (RD_LAT != 1) begin : g_bad_lat
    $error("arbiter assumes a one-clock RAM read latency");
  end

  arb_state_t        state;
  logic              slot_start;
  logic              last_gnt;
  logic              win_q;
  logic              we_q;
  logic              win_c;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              a_gnt_q;
  logic              b_gnt_q;
  logic              a_rvalid_q;
  logic              b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  slot_tick_gen #(
    .SLOT_CYC (SLOT_CYC)
  ) u_tick (
    .clk_100Mhz (clk_100Mhz),
    .Reset      (Reset),
    .slot_start (slot_start)
  );

  // Winner: sole requester, or on a tie the port that was not granted last.
  always_comb begin
    win_c = PORT_A;
    if (a_port.req && b_port.req) begin
      win_c = ~last_gnt;
    end else if (b_port.req) begin
      win_c = PORT_B;
    end
  end

  // Arbitration FSM with registered RAM, grant and read-valid outputs.
  always_ff @(posedge clk_100Mhz) begin
    if (Reset) begin
      state       <= IDLE;
      last_gnt    <= PORT_B;
      win_q       <= PORT_A;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      busy        <= 1'b0;
    end else begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (slot_start && (a_port.req || b_port.req)) begin
            state       <= ISSUE;
            busy        <= 1'b1;
            win_q       <= win_c;
            last_gnt    <= win_c;
            we_q        <= (win_c == PORT_B) ? b_port.we    : a_port.we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= (win_c == PORT_B) ? b_port.we    : a_port.we;
            mem_addr_q  <= (win_c == PORT_B) ? b_port.addr  : a_port.addr;
            mem_wdata_q <= (win_c == PORT_B) ? b_port.wdata : a_port.wdata;
            a_gnt_q     <= (win_c == PORT_A);
            b_gnt_q     <= (win_c == PORT_B);
          end
        end
        ISSUE: begin
          state      <= DONE;
          a_rvalid_q <= !we_q && (win_q == PORT_A);
          b_rvalid_q <= !we_q && (win_q == PORT_B);
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (a_rvalid_q) a_rdata_q <= ram.rdata;
          if (b_rvalid_q) b_rdata_q <= ram.rdata;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // RAM data arrives in DONE, so it passes straight through while rvalid is high.
  assign a_port.rdata  = a_rvalid_q ? ram.rdata : a_rdata_q;
  assign b_port.rdata  = b_rvalid_q ? ram.rdata : b_rdata_q;
  assign a_port.gnt    = a_gnt_q;
  assign b_port.gnt    = b_gnt_q;
  assign a_port.rvalid = a_rvalid_q;
  assign b_port.rvalid = b_rvalid_q;
  assign ram.en        = mem_en_q;
  assign ram.we        = mem_we_q;
  assign ram.addr      = mem_addr_q;
  assign ram.wdata     = mem_wdata_q;

endmodule

// File: tb/tb_single_mem_arbiter.sv
// Directed bench for single_mem_arbiter with a one-clock-latency RAM model.
module tb_single_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SLOT_CYC = 4;

  logic clk_100Mhz;
  logic Reset;
  logic busy;
  int   checks;
  int   errors;
  int   cyc;

  mem_arb_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
  mem_arb_req_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();
  mem_arb_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_if ();

  single_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SLOT_CYC (SLOT_CYC)
  ) dut (
    .clk_100Mhz (clk_100Mhz),
    .Reset      (Reset),
    .a_port     (a_if.slave),
    .b_port     (b_if.slave),
    .ram        (ram_if.master),
    .busy       (busy)
  );

  initial clk_100Mhz = 1'b0;
  always #5 clk_100Mhz = ~clk_100Mhz;

  // Synchronous single-port RAM, read data one clock after enable.
  logic [DATA_W-1:0] ram_arr [0:(1<<ADDR_W)-1];
  always @(posedge clk_100Mhz) begin
    if (ram_if.en) begin
      if (ram_if.we) ram_arr[ram_if.addr] <= ram_if.wdata;
      else           ram_if.rdata <= ram_arr[ram_if.addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100Mhz);
    #1;
    cyc++;
  endtask

  // Advance until the bench-tracked slot counter is back at 0.
  task automatic to_slot();
    for (int i = 0; i < int'(SLOT_CYC); i++) begin
      if (cyc % int'(SLOT_CYC) == 0) break;
      tick();
    end
  endtask

  task automatic set_a(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata);
    a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata);
    b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram_arr[i] = '0;
    ram_if.rdata = '0;
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);

    // 1: reset for 5 cycles, idle afterwards, slot_start every 4 clocks
    Reset = 1'b1;
    repeat (5) @(posedge clk_100Mhz);
    #1;
    Reset = 1'b0;
    cyc   = 0;
    chk("rst_a_gnt", 32'(a_if.gnt), 32'h0);
    chk("rst_b_gnt", 32'(b_if.gnt), 32'h0);
    chk("rst_a_rvalid", 32'(a_if.rvalid), 32'h0);
    chk("rst_b_rvalid", 32'(b_if.rvalid), 32'h0);
    chk("rst_a_rdata", 32'(a_if.rdata), 32'h0);
    chk("rst_b_rdata", 32'(b_if.rdata), 32'h0);
    chk("rst_mem_addr", 32'(ram_if.addr), 32'h0);
    chk("rst_mem_wdata", 32'(ram_if.wdata), 32'h0);
    for (int k = 0; k <= 8; k++) begin
      chk("idle_slot_start", 32'(dut.slot_start), (k % 4 == 0) ? 32'h1 : 32'h0);
      chk("idle_mem_en", 32'(ram_if.en), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      tick();
    end

    // 2: A writes 0xA5 to 0x005
    to_slot();
    set_a(1'b1, 1'b1, 10'h005, 8'hA5);
    tick();
    chk("wr_mem_en", 32'(ram_if.en), 32'h1);
    chk("wr_mem_we", 32'(ram_if.we), 32'h1);
    chk("wr_mem_addr", 32'(ram_if.addr), 32'h005);
    chk("wr_mem_wdata", 32'(ram_if.wdata), 32'hA5);
    chk("wr_a_gnt", 32'(a_if.gnt), 32'h1);
    chk("wr_b_gnt", 32'(b_if.gnt), 32'h0);
    chk("wr_busy", 32'(busy), 32'h1);
    set_a(1'b0, 1'b0, '0, '0);
    tick();
    chk("wr_a_gnt_off", 32'(a_if.gnt), 32'h0);
    chk("wr_no_rvalid", 32'(a_if.rvalid), 32'h0);
    chk("wr_mem_en_off", 32'(ram_if.en), 32'h0);
    chk("wr_busy_done", 32'(busy), 32'h1);
    tick();
    chk("wr_no_rvalid2", 32'(a_if.rvalid), 32'h0);
    chk("wr_busy_idle", 32'(busy), 32'h0);
    chk("wr_addr_hold", 32'(ram_if.addr), 32'h005);

    // 3: B reads 0x005 back
    to_slot();
    set_b(1'b1, 1'b0, 10'h005, 8'h00);
    tick();
    chk("rd_mem_en", 32'(ram_if.en), 32'h1);
    chk("rd_mem_we", 32'(ram_if.we), 32'h0);
    chk("rd_mem_addr", 32'(ram_if.addr), 32'h005);
    chk("rd_b_gnt", 32'(b_if.gnt), 32'h1);
    chk("rd_a_gnt", 32'(a_if.gnt), 32'h0);
    chk("rd_b_rvalid_early", 32'(b_if.rvalid), 32'h0);
    set_b(1'b0, 1'b0, '0, '0);
    tick();
    chk("rd_b_rvalid", 32'(b_if.rvalid), 32'h1);
    chk("rd_b_rdata", 32'(b_if.rdata), 32'hA5);
    chk("rd_a_rvalid", 32'(a_if.rvalid), 32'h0);
    tick();
    chk("rd_b_rvalid_off", 32'(b_if.rvalid), 32'h0);
    chk("rd_b_rdata_hold", 32'(b_if.rdata), 32'hA5);

    // 4: both request for four slots -> A, B, A, B
    to_slot();
    set_a(1'b1, 1'b1, 10'h010, 8'h11);
    set_b(1'b1, 1'b0, 10'h020, 8'h00);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("rr_a_gnt", 32'(a_if.gnt), (k == 1 || k == 9) ? 32'h1 : 32'h0);
      chk("rr_b_gnt", 32'(b_if.gnt), (k == 5 || k == 13) ? 32'h1 : 32'h0);
    end
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);

    // 5: A raises a read at cnt=1 and waits for the next slot
    to_slot();
    tick();
    set_a(1'b1, 1'b0, 10'h005, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("late_a_gnt", 32'(a_if.gnt), (k == 4) ? 32'h1 : 32'h0);
      chk("late_a_rvalid", 32'(a_if.rvalid), (k == 5) ? 32'h1 : 32'h0);
      if (k == 4) set_a(1'b0, 1'b0, '0, '0);
      if (k == 5) chk("late_a_rdata", 32'(a_if.rdata), 32'hA5);
    end

    // 6: reset during B's ISSUE cycle, then a tie goes to A
    to_slot();
    set_b(1'b1, 1'b0, 10'h010, 8'h00);
    tick();
    chk("rst6_b_gnt", 32'(b_if.gnt), 32'h1);
    Reset = 1'b1;
    set_b(1'b0, 1'b0, '0, '0);
    tick();
    chk("rst6_mem_en", 32'(ram_if.en), 32'h0);
    chk("rst6_b_rvalid", 32'(b_if.rvalid), 32'h0);
    chk("rst6_b_gnt_off", 32'(b_if.gnt), 32'h0);
    chk("rst6_busy", 32'(busy), 32'h0);
    chk("rst6_b_rdata", 32'(b_if.rdata), 32'h0);
    tick();
    chk("rst6_b_rvalid2", 32'(b_if.rvalid), 32'h0);
    Reset = 1'b0;
    cyc   = 0;
    set_a(1'b1, 1'b1, 10'h030, 8'h33);
    set_b(1'b1, 1'b0, 10'h010, 8'h00);
    tick();
    chk("post_a_gnt", 32'(a_if.gnt), 32'h1);
    chk("post_b_gnt", 32'(b_if.gnt), 32'h0);
    set_a(1'b0, 1'b0, '0, '0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk("post_b_gnt_seq", 32'(b_if.gnt), (k == 5) ? 32'h1 : 32'h0);
      if (k == 5) set_b(1'b0, 1'b0, '0, '0);
      if (k == 6) begin
        chk("post_b_rvalid", 32'(b_if.rvalid), 32'h1);
        chk("post_b_rdata", 32'(b_if.rdata), 32'h11);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
